// File: rtl/hdc_pkg.sv
// rtl/hdc_pkg.sv - shared hypervector types, sizing constants and rotation helper
`ifndef HV_DIMENSION
`define HV_DIMENSION 1024
`endif

package hdc_pkg;

    localparam int HV_DIM         = `HV_DIMENSION;
    localparam int MAX_NGRAM_SIZE = 8;
    localparam int FILL_W         = $clog2(MAX_NGRAM_SIZE);

    typedef logic [HV_DIM-1:0] hv_t;

    // Rotate left by k bits (k limited to the largest window length).
    function automatic hv_t hv_rotate(hv_t x, int k);
        hv_t r;
        r = x;
        for (int i = 0; i < MAX_NGRAM_SIZE; i++) begin
            if (i < k) begin
                r = {r[HV_DIM-2:0], r[HV_DIM-1]};
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/temporal_history.sv
// rtl/temporal_history.sv - shift register of past spatial hypervectors, entry 0 is the newest
module temporal_history #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        shift_en,
    input  logic                        clear,
    input  logic [WIDTH-1:0]            din,
    output logic [DEPTH-1:0][WIDTH-1:0] entries
);

    // Clear wins over shift so a restart never keeps a stale sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            entries <= '0;
        end else if (clear) begin
            entries <= '0;
        end else if (shift_en) begin
            entries[0] <= din;
            for (int k = 1; k < DEPTH; k++) begin
                entries[k] <= entries[k-1];
            end
        end
    end

endmodule

// File: rtl/temporal_encoder.sv
// rtl/temporal_encoder.sv - n-gram binder of spatial hypervectors by rotate-and-XOR; TEMPORAL_NONOVERLAP_EN selects non-overlapping windows
module temporal_encoder #(
    parameter int HV_DIM     = hdc_pkg::HV_DIM,
    parameter int NGRAM_SIZE = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hvin_valid,
    output logic              hvin_ready,
    input  logic [HV_DIM-1:0] hvin,
    input  logic              flush,
    output logic              hvout_valid,
    input  logic              hvout_ready,
    output logic [HV_DIM-1:0] hvout
);

    import hdc_pkg::*;

    localparam int                HIST_DEPTH = (NGRAM_SIZE > 1) ? NGRAM_SIZE - 1 : 1;
    localparam logic [FILL_W-1:0] FILL_MAX   = FILL_W'(NGRAM_SIZE - 1);

`ifdef TEMPORAL_NONOVERLAP_EN
    localparam bit NONOVERLAP = 1'b1;
`else
    localparam bit NONOVERLAP = 1'b0;
`endif

    logic [FILL_W-1:0]                    fill;
    logic [HIST_DEPTH-1:0][HV_DIM-1:0]    hist;
    logic [HV_DIM-1:0]                    ngram;
    logic                                 in_fire;
    logic                                 out_fire;
    logic                                 window_full;
    logic                                 hist_clear;

    function automatic logic [HV_DIM-1:0] rotl(input logic [HV_DIM-1:0] x, input int k);
        logic [HV_DIM-1:0] r;
        r = x;
        for (int i = 0; i < MAX_NGRAM_SIZE; i++) begin
            if (i < k) begin
                r = {r[HV_DIM-2:0], r[HV_DIM-1]};
            end
        end
        return r;
    endfunction

    // Single output register: a new input may enter in the same cycle the old result drains.
    assign hvin_ready  = !flush && (!hvout_valid || hvout_ready);
    assign in_fire     = hvin_valid && hvin_ready;
    assign out_fire    = hvout_valid && hvout_ready;
    assign window_full = (fill == FILL_MAX);
    assign hist_clear  = flush || (NONOVERLAP && in_fire && window_full);

    generate
        if (NGRAM_SIZE > 1) begin : g_hist
            temporal_history #(
                .WIDTH (HV_DIM),
                .DEPTH (HIST_DEPTH)
            ) u_history (
                .clk      (clk),
                .rst      (rst),
                .shift_en (in_fire),
                .clear    (hist_clear),
                .din      (hvin),
                .entries  (hist)
            );
        end else begin : g_no_hist
            assign hist = '0;
        end
    endgenerate

    // XOR tree over the pre-shift history: hist[k-1] holds h_{t-k}.
    always_comb begin
        ngram = hvin;
        for (int k = 1; k < NGRAM_SIZE; k++) begin
            ngram = ngram ^ rotl(hist[k-1], k);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fill        <= '0;
            hvout       <= '0;
            hvout_valid <= 1'b0;
        end else begin
            if (flush) begin
                fill <= '0;
            end else if (in_fire) begin
                if (!window_full) begin
                    fill <= fill + 1'b1;
                end else if (NONOVERLAP) begin
                    fill <= '0;
                end
            end

            if (in_fire && window_full) begin
                hvout       <= ngram;
                hvout_valid <= 1'b1;
            end else if (out_fire) begin
                hvout_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_temporal_encoder.sv
// tb/tb_temporal_encoder.sv - directed vector bench for temporal_encoder (N=3 and N=1, 8-bit)
module tb_temporal_encoder;

`ifdef TEMPORAL_NONOVERLAP_EN
    localparam bit SLIDE = 1'b0;
`else
    localparam bit SLIDE = 1'b1;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       valid = 1'b0, oready = 1'b1, flush = 1'b0;
    logic [7:0] din = 8'h00;
    logic       iready, ovalid;
    logic [7:0] dout;
    logic       valid1 = 1'b0, oready1 = 1'b1, flush1 = 1'b0;
    logic [7:0] din1 = 8'h00;
    logic       iready1, ovalid1;
    logic [7:0] dout1;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       r;
        logic       f;
        logic       e_ir;
        logic       e_ov;
        logic [7:0] e_out;
    } vec_t;

    vec_t tbl [7];

    always #5 clk = ~clk;

    temporal_encoder #(.HV_DIM(8), .NGRAM_SIZE(3)) dut (
        .clk         (clk),
        .rst         (rst),
        .hvin_valid  (valid),
        .hvin_ready  (iready),
        .hvin        (din),
        .flush       (flush),
        .hvout_valid (ovalid),
        .hvout_ready (oready),
        .hvout       (dout)
    );

    temporal_encoder #(.HV_DIM(8), .NGRAM_SIZE(1)) dut1 (
        .clk         (clk),
        .rst         (rst),
        .hvin_valid  (valid1),
        .hvin_ready  (iready1),
        .hvin        (din1),
        .flush       (flush1),
        .hvout_valid (ovalid1),
        .hvout_ready (oready1),
        .hvout       (dout1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input string name, input logic v, input logic [7:0] d, input logic r,
                        input logic f, input logic e_ir, input logic e_ov, input logic [7:0] e_out);
        @(negedge clk);
        valid  = v;
        din    = d;
        oready = r;
        flush  = f;
        #1;
        check({name, "_in_ready"}, 32'(iready), 32'(e_ir));
        @(posedge clk);
        #1;
        check({name, "_out_valid"}, 32'(ovalid), 32'(e_ov));
        check({name, "_out"}, 32'(dout), 32'(e_out));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst    = 1'b1;
        valid  = 1'b0;
        flush  = 1'b0;
        oready = 1'b1;
        @(negedge clk);
        #1;
        check("rst_out_valid", 32'(ovalid), 32'd0);
        check("rst_out", 32'(dout), 32'd0);
        rst = 1'b0;
        #1;
        check("rst_in_ready", 32'(iready), 32'd1);
    endtask

    task automatic step1(input string name, input logic v, input logic [7:0] d,
                         input logic e_ov, input logic [7:0] e_out);
        @(negedge clk);
        valid1 = v;
        din1   = d;
        #1;
        check({name, "_in_ready"}, 32'(iready1), 32'd1);
        @(posedge clk);
        #1;
        check({name, "_out_valid"}, 32'(ovalid1), 32'(e_ov));
        check({name, "_out"}, 32'(dout1), 32'(e_out));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{1'b1, 8'h01, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00};
        tbl[1] = '{1'b1, 8'h02, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00};
        tbl[2] = '{1'b1, 8'h04, 1'b1, 1'b0, 1'b1, 1'b1, 8'h04};
        tbl[3] = '{1'b1, 8'h80, 1'b1, 1'b0, 1'b1, SLIDE, SLIDE ? 8'h80 : 8'h04};
        tbl[4] = '{1'b1, 8'h03, 1'b1, 1'b0, 1'b1, SLIDE, SLIDE ? 8'h12 : 8'h04};
        tbl[5] = '{1'b1, 8'h40, 1'b1, 1'b0, 1'b1, 1'b1, 8'h44};
        tbl[6] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h44};

        // Fill-up and sliding window from the vector table.
        do_reset();
        for (int i = 0; i < 7; i++) begin
            step($sformatf("vec%0d", i), tbl[i].v, tbl[i].d, tbl[i].r, tbl[i].f,
                 tbl[i].e_ir, tbl[i].e_ov, tbl[i].e_out);
        end

        // Backpressure: output held, input refused, then drain plus accept together.
        do_reset();
        step("bp_a", 1'b1, 8'h01, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
        step("bp_b", 1'b1, 8'h02, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
        step("bp_c", 1'b1, 8'h04, 1'b0, 1'b0, 1'b1, 1'b1, 8'h04);
        for (int i = 0; i < 5; i++) begin
            step($sformatf("bp_hold%0d", i), 1'b1, 8'h80, 1'b0, 1'b0, 1'b0, 1'b1, 8'h04);
        end
        step("bp_release", 1'b1, 8'h80, 1'b1, 1'b0, 1'b1, SLIDE, SLIDE ? 8'h80 : 8'h04);

        // Flush restarts the window and refuses the coincident input.
        do_reset();
        step("fl_a", 1'b1, 8'h01, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
        step("fl_b", 1'b1, 8'h02, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
        step("fl_flush", 1'b1, 8'h04, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        step("fl_c", 1'b1, 8'h01, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
        step("fl_d", 1'b1, 8'h02, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
        step("fl_e", 1'b1, 8'h04, 1'b0, 1'b0, 1'b1, 1'b1, 8'h04);
        step("fl_pending", 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 8'h04);
        step("fl_drain", 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h04);

        // Asynchronous reset with an output pending.
        do_reset();
        step("rm_a", 1'b1, 8'h01, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
        step("rm_b", 1'b1, 8'h02, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
        step("rm_c", 1'b1, 8'h04, 1'b0, 1'b0, 1'b1, 1'b1, 8'h04);
        @(negedge clk);
        valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("rm_async_out_valid", 32'(ovalid), 32'd0);
        check("rm_async_out", 32'(dout), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rm_in_ready", 32'(iready), 32'd1);
        step("rm_d", 1'b1, 8'h01, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
        step("rm_e", 1'b1, 8'h02, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
        step("rm_f", 1'b1, 8'h04, 1'b1, 1'b0, 1'b1, 1'b1, 8'h04);
        step("rm_g", 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h04);

        // N=1: every accepted input is its own output.
        step1("n1_a", 1'b1, 8'hA5, 1'b1, 8'hA5);
        step1("n1_b", 1'b1, 8'h3C, 1'b1, 8'h3C);
        step1("n1_idle", 1'b0, 8'h00, 1'b0, 8'h3C);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
